// File: rtl/spm_pkg.sv
// Shared constants for the RISC SPM core: word width, opcodes and bus-select codes.
// The controller imports the same package, so these codes are the contract between the two.
package spm_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    AND = 4'd3,
    NOT = 4'd4,
    RD  = 4'd5,
    WR  = 4'd6,
    BR  = 4'd7,
    BRZ = 4'd8
  } opcode_e;

  localparam logic [2:0] SEL_R0 = 3'd0;
  localparam logic [2:0] SEL_R1 = 3'd1;
  localparam logic [2:0] SEL_R2 = 3'd2;
  localparam logic [2:0] SEL_R3 = 3'd3;
  localparam logic [2:0] SEL_PC = 3'd4;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_BUS1 = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd3;

endpackage

// File: rtl/spm_alu.sv
// Combinational ALU. Operand a is bus_1 and operand b is Y; arithmetic wraps at the word width.
module spm_alu
  import spm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (opcode)
      ADD:     result = b + a;
      SUB:     result = a - b;  // dest (bus_1) minus src (Y)
      AND:     result = b & a;
      NOT:     result = ~a;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/spm_datapath.sv
// SPM processing unit: R0-R3, PC, IR, Y, Z and the address register, plus both buses.
// Every controller strobe takes effect on the next rising edge of clk.
module spm_datapath
  import spm_pkg::*;
#(
  parameter int WORD_W = spm_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_R0,
  input  logic              load_R1,
  input  logic              load_R2,
  input  logic              load_R3,
  input  logic              load_PC,
  input  logic              inc_PC,
  input  logic              load_IR,
  input  logic              load_Y,
  input  logic              load_Z,
  input  logic              load_addr,
  input  logic [2:0]        sel_mux1,
  input  logic [1:0]        sel_mux2,
  input  logic [WORD_W-1:0] mem_word,
  output logic [WORD_W-1:0] instr,
  output logic              zero_flag,
  output logic [WORD_W-1:0] address,
  output logic [WORD_W-1:0] bus_1
);

  logic [WORD_W-1:0] r_q [4];
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] ir_q, y_q, addr_q;
  logic              z_q;
  logic [WORD_W-1:0] bus_2;
  logic [WORD_W-1:0] alu_out;
  logic              alu_zero;
  logic [3:0]        load_r;

  assign load_r = {load_R3, load_R2, load_R1, load_R0};

  // Unused or unknown select codes park the bus at zero.
  always_comb begin
    bus_1 = '0;
    case (sel_mux1)
      SEL_R0:  bus_1 = r_q[0];
      SEL_R1:  bus_1 = r_q[1];
      SEL_R2:  bus_1 = r_q[2];
      SEL_R3:  bus_1 = r_q[3];
      SEL_PC:  bus_1 = pc_q;
      default: bus_1 = '0;
    endcase
  end

  always_comb begin
    bus_2 = '0;
    case (sel_mux2)
      SEL_ALU:  bus_2 = alu_out;
      SEL_BUS1: bus_2 = bus_1;
      SEL_MEM:  bus_2 = mem_word;
      default:  bus_2 = '0;
    endcase
  end

  spm_alu #(.W(WORD_W)) u_alu (
    .opcode (ir_q[WORD_W-1 -: 4]),
    .a      (bus_1),
    .b      (y_q),
    .result (alu_out),
    .zero   (alu_zero)
  );

  always_comb begin
    pc_d = pc_q;
    if (load_PC)
      pc_d = bus_2;
    else if (inc_PC)
      pc_d = pc_q + 1'b1;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_gpr
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        r_q[gi] <= '0;
      else if (load_r[gi])
        r_q[gi] <= bus_2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      y_q    <= '0;
      addr_q <= '0;
      z_q    <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (load_IR)   ir_q   <= bus_2;
      if (load_Y)    y_q    <= bus_2;
      if (load_addr) addr_q <= bus_2;
      if (load_Z)    z_q    <= alu_zero;
    end
  end

  assign instr     = ir_q;
  assign zero_flag = z_q;
  assign address   = addr_q;

endmodule

// File: tb/tb_spm_datapath.sv
// Directed bench for spm_datapath: drives controller strobes, observes state through bus_1 and outputs.
module tb_spm_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_R0 = 0, load_R1 = 0, load_R2 = 0, load_R3 = 0;
  logic       load_PC = 0, inc_PC = 0, load_IR = 0, load_Y = 0;
  logic       load_Z = 0, load_addr = 0;
  logic [2:0] sel_mux1 = 3'd0;
  logic [1:0] sel_mux2 = 2'd0;
  logic [7:0] mem_word = 8'h00;
  logic [7:0] instr, address, bus_1;
  logic       zero_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spm_datapath #(.WORD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_R0   (load_R0),
    .load_R1   (load_R1),
    .load_R2   (load_R2),
    .load_R3   (load_R3),
    .load_PC   (load_PC),
    .inc_PC    (inc_PC),
    .load_IR   (load_IR),
    .load_Y    (load_Y),
    .load_Z    (load_Z),
    .load_addr (load_addr),
    .sel_mux1  (sel_mux1),
    .sel_mux2  (sel_mux2),
    .mem_word  (mem_word),
    .instr     (instr),
    .zero_flag (zero_flag),
    .address   (address),
    .bus_1     (bus_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clock edge, then drop every strobe so the next step starts clean.
  task automatic cycle();
    @(posedge clk);
    #1;
    {load_R0, load_R1, load_R2, load_R3, load_PC, inc_PC} = '0;
    {load_IR, load_Y, load_Z, load_addr} = '0;
  endtask

  task automatic load_reg(input int idx, input logic [7:0] val);
    mem_word = val;
    sel_mux2 = 2'd3;
    case (idx)
      0: load_R0 = 1;
      1: load_R1 = 1;
      2: load_R2 = 1;
      default: load_R3 = 1;
    endcase
    cycle();
  endtask

  task automatic load_ir(input logic [7:0] val);
    mem_word = val; sel_mux2 = 2'd3; load_IR = 1;
    cycle();
  endtask

  task automatic load_pc(input logic [7:0] val);
    mem_word = val; sel_mux2 = 2'd3; load_PC = 1;
    cycle();
  endtask

  task automatic load_y_from(input logic [2:0] src);
    sel_mux1 = src; sel_mux2 = 2'd1; load_Y = 1;
    cycle();
  endtask

  task automatic chk_bus1(input string tag, input logic [2:0] sel, input logic [7:0] exp);
    sel_mux1 = sel;
    #1;
    check(tag, bus_1, exp);
  endtask

  initial begin
    // Reset held from time 0
    #12;
    check("rst_instr", instr, 8'h00);
    check("rst_zero", zero_flag, 1'b0);
    check("rst_address", address, 8'h00);
    chk_bus1("rst_pc", 3'd4, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Build up state, then assert reset mid-cycle
    load_reg(2, 8'h5A);
    load_pc(8'h10);
    mem_word = 8'h77; sel_mux2 = 2'd3; load_addr = 1; cycle();
    load_Z = 1; cycle();  // IR = NOP so ALU result is 0 -> Z = 1
    chk_bus1("pre_rst_r2", 3'd2, 8'h5A);
    chk_bus1("pre_rst_pc", 3'd4, 8'h10);
    check("pre_rst_addr", address, 8'h77);
    check("pre_rst_z", zero_flag, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_addr", address, 8'h00);
    check("mid_rst_z", zero_flag, 1'b0);
    chk_bus1("mid_rst_r2", 3'd2, 8'h00);
    chk_bus1("mid_rst_pc", 3'd4, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Fetch from PC = 0; preload address so fet1 visibly rewrites it
    mem_word = 8'h55; sel_mux2 = 2'd3; load_addr = 1; cycle();
    check("addr_preload", address, 8'h55);
    mem_word = 8'h16;
    sel_mux1 = 3'd4; sel_mux2 = 2'd1; load_addr = 1; cycle();
    check("fet1_addr", address, 8'h00);
    sel_mux2 = 2'd3; load_IR = 1; inc_PC = 1; cycle();
    check("fet2_instr", instr, 8'h16);
    chk_bus1("fet2_pc", 3'd4, 8'h01);

    // ADD R1 into R2 with wrap: 0xFF + 0x01 = 0x00, Z set
    load_reg(1, 8'hFF);
    load_reg(2, 8'h01);
    load_y_from(3'd1);
    sel_mux1 = 3'd2; sel_mux2 = 2'd0; load_R2 = 1; load_Z = 1; cycle();
    chk_bus1("add_r2", 3'd2, 8'h00);
    check("add_z", zero_flag, 1'b1);
    chk_bus1("add_r1_kept", 3'd1, 8'hFF);

    // SUB R0 - R3, result also captured into R1 in the same edge
    load_reg(0, 8'h09);
    check("z_hold", zero_flag, 1'b1);
    load_reg(3, 8'h04);
    load_ir(8'h2C);
    load_y_from(3'd3);
    sel_mux1 = 3'd0; sel_mux2 = 2'd0; load_R0 = 1; load_R1 = 1; load_Z = 1; cycle();
    chk_bus1("sub_r0", 3'd0, 8'h05);
    chk_bus1("sub_r1_same", 3'd1, 8'h05);
    check("sub_z", zero_flag, 1'b0);

    // NOT R0 -> R1
    load_ir(8'h41);
    load_reg(0, 8'h0F);
    sel_mux1 = 3'd0; sel_mux2 = 2'd0; load_R1 = 1; cycle();
    chk_bus1("not_r1", 3'd1, 8'hF0);

    // PC wrap and load priority over increment
    load_pc(8'hFF);
    inc_PC = 1; cycle();
    chk_bus1("pc_wrap", 3'd4, 8'h00);
    mem_word = 8'h33; sel_mux2 = 2'd3; load_PC = 1; inc_PC = 1; cycle();
    chk_bus1("pc_prio", 3'd4, 8'h33);

    // Illegal selects park the buses at zero
    chk_bus1("mux1_code6", 3'd6, 8'h00);
    sel_mux2 = 2'd2; load_R3 = 1; cycle();
    chk_bus1("mux2_code2_r3", 3'd3, 8'h00);
    chk_bus1("keep_r0", 3'd0, 8'h0F);
    chk_bus1("keep_r1", 3'd1, 8'hF0);
    chk_bus1("keep_r2", 3'd2, 8'h00);
    chk_bus1("keep_pc", 3'd4, 8'h33);
    check("keep_instr", instr, 8'h41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
